// File: rtl/ir_rx_pkg.sv
// ir_rx_pkg: shared state/drop-cause types and frame delimiter codes for the
// IR receive framer.
package ir_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } ir_rx_state_t;

  // Why the frame in progress was rolled back (debug visibility only).
  typedef enum logic [2:0] {
    DROP_NONE     = 3'd0,
    DROP_OVERFLOW = 3'd1,
    DROP_LENGTH   = 3'd2,
    DROP_ERROR    = 3'd3,
    DROP_RESTART  = 3'd4,
    DROP_CHECKSUM = 3'd5,
    DROP_EMPTY    = 3'd6
  } ir_rx_drop_t;

  // Start-of-frame is the all-ones code.
  function automatic logic [31:0] SOF_CODE(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // End-of-frame is one below start-of-frame.
  function automatic logic [31:0] EOF_CODE(input int unsigned w);
    return (32'd1 << w) - 32'd2;
  endfunction

endpackage

// File: rtl/ir_rx_fifo_mem.sv
// ir_rx_fifo_mem: DEPTH x DATA_WIDTH simple dual-port store with synchronous
// write and a registered read port. No reset on the array or read register.
module ir_rx_fifo_mem #(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read; a same-cycle write to this address returns old data.
  always_ff @(posedge i_clk) begin
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/ir_rx_frame_buffer.sv
// ir_rx_frame_buffer: assembles SOF/EOF-delimited IR codes into frames,
// writes payload speculatively into a FIFO, commits clean frames and rolls
// back broken ones. Committed letters drain on a valid/ready port.
// Build option: define IR_RX_CHECKSUM_EN to treat the last code before EOF as
// a modulo-2^DATA_WIDTH checksum of the preceding letters.
module ir_rx_frame_buffer
  import ir_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 16,
  parameter int MAX_FRAME  = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [DATA_WIDTH-1:0]   code_in,
  input  logic                    code_valid_in,
  input  logic                    error_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid_out,
  input  logic                    data_ready_in,
  output logic                    frame_done_out,
  output logic                    frame_drop_out,
  output logic [$clog2(DEPTH):0]  count_out,
  output logic [7:0]              drop_count_out,
  output logic                    state_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_FRAME + 1);
  localparam logic [DATA_WIDTH-1:0] SOF_C   = DATA_WIDTH'(SOF_CODE(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] EOF_C   = DATA_WIDTH'(EOF_CODE(DATA_WIDTH));
  localparam logic [PW-1:0]         DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]         ONE_P   = PW'(1);
  localparam logic [LW-1:0]         MAXF_L  = LW'(MAX_FRAME);
  localparam logic [LW-1:0]         ONE_L   = LW'(1);

  ir_rx_state_t          r_state;
  logic [PW-1:0]         r_rd_ptr, r_commit_ptr, r_wr_ptr, r_count;
  logic [LW-1:0]         r_len;
  logic                  r_valid, r_done, r_drop;
  logic [7:0]            r_drop_cnt;
`ifdef IR_RX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_sum, r_sum_prev, r_last;
`endif

  logic                  w_pop, w_full, w_write, w_commit, w_drop;
  ir_rx_drop_t           w_cause;
  logic [PW-1:0]         w_rd_nxt, w_commit_val, w_commit_nxt;
  logic [DATA_WIDTH-1:0] w_mem_q;

  assign w_pop    = r_valid & data_ready_in;
  assign w_rd_nxt = r_rd_ptr + (w_pop ? ONE_P : '0);
  // Full uses this cycle's rd_ptr: a pop frees space only from next cycle.
  assign w_full   = (r_wr_ptr - r_rd_ptr) == DEPTH_P;

`ifdef IR_RX_CHECKSUM_EN
  // Checksum entry is never released; wr_ptr also steps back over it so it
  // does not linger as a stale speculative entry ahead of the next frame.
  assign w_commit_val = r_wr_ptr - ONE_P;
`else
  assign w_commit_val = r_wr_ptr;
`endif
  assign w_commit_nxt = w_commit ? w_commit_val : r_commit_ptr;

  // Classify this cycle's input while receiving: write, commit or drop cause.
  always_comb begin
    w_cause  = DROP_NONE;
    w_write  = 1'b0;
    w_commit = 1'b0;
    if (r_state == RECV) begin
      if (error_in) begin
        w_cause = DROP_ERROR;
      end else if (code_valid_in) begin
        if (code_in == SOF_C) begin
          w_cause = DROP_RESTART;
        end else if (code_in == EOF_C) begin
          if (r_len == '0) w_cause = DROP_EMPTY;
`ifdef IR_RX_CHECKSUM_EN
          else if (r_len == ONE_L) w_cause = DROP_LENGTH;
          else if (r_sum_prev != r_last) w_cause = DROP_CHECKSUM;
`endif
          else w_commit = 1'b1;
        end else begin
          if (r_len == MAXF_L) w_cause = DROP_LENGTH;
          else if (w_full) w_cause = DROP_OVERFLOW;
          else w_write = 1'b1;
        end
      end
    end
  end

  assign w_drop = (w_cause != DROP_NONE);

  ir_rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .i_clk     (clk_in),
    .i_wr_en   (w_write),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (code_in),
    .i_rd_addr (w_rd_nxt[AW-1:0]),
    .o_rd_data (w_mem_q)
  );

  // Pointers, framing FSM, status pulses and output-side registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_rd_ptr     <= '0;
      r_commit_ptr <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_len        <= '0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_drop       <= 1'b0;
      r_drop_cnt   <= '0;
`ifdef IR_RX_CHECKSUM_EN
      r_sum        <= '0;
      r_sum_prev   <= '0;
      r_last       <= '0;
`endif
    end else begin
      r_rd_ptr     <= w_rd_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_count      <= w_commit_nxt - w_rd_nxt;
      // Judged against the pre-commit pointer so a new commit becomes
      // visible one cycle later, once the read stage has fetched its head.
      r_valid      <= (r_commit_ptr != w_rd_nxt);
      r_done       <= w_commit;
      r_drop       <= w_drop;
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      case (r_state)
        IDLE: begin
          if (code_valid_in && !error_in && code_in == SOF_C) begin
            r_state <= RECV;
            r_len   <= '0;
`ifdef IR_RX_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end
        end
        RECV: begin
          if (w_drop) begin
            r_wr_ptr <= r_commit_ptr;
            r_len    <= '0;
`ifdef IR_RX_CHECKSUM_EN
            r_sum    <= '0;
`endif
            // A restart SOF opens a fresh frame immediately.
            if (w_cause != DROP_RESTART) r_state <= IDLE;
          end else if (w_commit) begin
            r_wr_ptr <= w_commit_val;
            r_state  <= IDLE;
          end else if (w_write) begin
            r_wr_ptr   <= r_wr_ptr + ONE_P;
            r_len      <= r_len + ONE_L;
`ifdef IR_RX_CHECKSUM_EN
            r_sum_prev <= r_sum;
            r_sum      <= r_sum + code_in;
            r_last     <= code_in;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out       = r_valid ? w_mem_q : '0;
  assign data_valid_out = r_valid;
  assign frame_done_out = r_done;
  assign frame_drop_out = r_drop;
  assign count_out      = r_count;
  assign drop_count_out = r_drop_cnt;
  assign state_out      = r_state;

endmodule

// File: tb/tb_ir_rx_frame_buffer.sv
// tb_ir_rx_frame_buffer: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the framer.
module tb_ir_rx_frame_buffer;

  localparam int DW = 5, DEPTH = 16, MAXF = 16, PW = 5;
  localparam logic [DW-1:0] SOF = 5'd31, EOF = 5'd30;
`ifdef IR_RX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef logic [DW-1:0] q_t [$];
  typedef struct packed { logic v; logic [DW-1:0] c; logic e; } stim_t;

  logic          clk_in = 1'b0, rst_in = 1'b1;
  logic [DW-1:0] code_in = '0, data_out;
  logic          code_valid_in = 1'b0, error_in = 1'b0, data_ready_in = 1'b0;
  logic          data_valid_out, frame_done_out, frame_drop_out, state_out;
  logic [PW-1:0] count_out;
  logic [7:0]    drop_count_out;

  int checks = 0, failures = 0;

  ir_rx_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_FRAME(MAXF)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .code_in(code_in), .code_valid_in(code_valid_in),
    .error_in(error_in), .data_out(data_out), .data_valid_out(data_valid_out),
    .data_ready_in(data_ready_in), .frame_done_out(frame_done_out),
    .frame_drop_out(frame_drop_out), .count_out(count_out),
    .drop_count_out(drop_count_out), .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: committed-unread letters and the frame being received.
  q_t cq, fq;
  bit m_recv, m_valid, m_done, m_drop;
  logic [DW-1:0] m_data;
  int m_count, m_dropcnt;

  // Bench bookkeeping of what the DUT did during stepped cycles.
  q_t popped;
  int popcyc[$];
  int cyc = 0, dut_dones = 0, dut_drops = 0, last_drop_cyc = -1;

  task automatic m_reset();
    cq.delete(); fq.delete();
    m_recv = 0; m_valid = 0; m_done = 0; m_drop = 0; m_data = '0;
    m_count = 0; m_dropcnt = 0;
  endtask

  // One clock edge of the framer's rules applied to the model.
  task automatic model_edge(input bit v, input logic [DW-1:0] c, input bit e, input bit r);
    int cqb, n, s; bit pop, ok; logic [DW-1:0] last;
    cqb = cq.size(); pop = m_valid && r;
    m_done = 0; m_drop = 0;
    if (!m_recv) begin
      if (v && !e && c == SOF) begin m_recv = 1; fq.delete(); end
    end else if (e) m_drop = 1;
    else if (v) begin
      if (c == SOF) m_drop = 1;
      else if (c == EOF) begin
        n = fq.size(); s = 0;
        for (int i = 0; i < n - 1; i++) s += int'(fq[i]);
        last = (n > 0) ? fq[n-1] : '0;
        ok = CK ? (n >= 2 && DW'(s) == last) : (n >= 1);
        if (ok) begin
          for (int i = 0; i < (CK ? n - 1 : n); i++) cq.push_back(fq[i]);
          fq.delete(); m_done = 1; m_recv = 0;
        end else m_drop = 1;
      end else if (fq.size() == MAXF || fq.size() + cqb == DEPTH) m_drop = 1;
      else fq.push_back(c);
    end
    if (m_drop) begin
      fq.delete();
      if (m_dropcnt < 255) m_dropcnt++;
      m_recv = (v && !e && c == SOF);
    end
    if (pop) void'(cq.pop_front());
    m_valid = (cqb - (pop ? 1 : 0)) > 0;
    m_data  = m_valid ? cq[0] : '0;
    m_count = cq.size();
  endtask

  // Drive one cycle from a negedge, advance model, return at next negedge.
  task automatic step(input bit v, input logic [DW-1:0] c, input bit e, input bit r);
    code_valid_in = v; code_in = c; error_in = e; data_ready_in = r;
    if (data_valid_out && r) begin popped.push_back(data_out); popcyc.push_back(cyc); end
    @(posedge clk_in);
    model_edge(v, c, e, r);
    @(negedge clk_in);
    cyc++;
    code_valid_in = 0; error_in = 0;
    if (frame_done_out) dut_dones++;
    if (frame_drop_out) begin dut_drops++; last_drop_cyc = cyc; end
  endtask

  task automatic send(input q_t codes, input bit r);
    foreach (codes[i]) step(1'b1, codes[i], 1'b0, r);
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) step(1'b0, '0, 1'b0, r);
  endtask

  task automatic clear_log();
    popped.delete(); popcyc.delete(); dut_dones = 0; dut_drops = 0; last_drop_cyc = -1;
  endtask

  function automatic q_t mk_frame(input q_t letters);
    q_t f; int s = 0;
    f.push_back(SOF);
    foreach (letters[i]) begin f.push_back(letters[i]); s += int'(letters[i]); end
    if (CK) f.push_back(DW'(s));
    f.push_back(EOF);
    return f;
  endfunction

  function automatic bit q_eq(input q_t a, input q_t b);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction

  task automatic apply_reset();
    rst_in = 1; code_valid_in = 0; error_in = 0; data_ready_in = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    m_reset(); clear_log();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({data_valid_out, frame_done_out, frame_drop_out, state_out} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=0000", {data_valid_out, frame_done_out, frame_drop_out, state_out}); end
    checks++; if (data_out !== '0) begin failures++; $display("FAIL reset_data got=%0d want=0", data_out); end
    checks++; if (count_out !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", count_out); end
    checks++; if (drop_count_out !== 8'd0) begin failures++; $display("FAIL reset_dropcnt got=%0d want=0", drop_count_out); end
    rst_in = 0;
  endtask

  task automatic test_basic();
    q_t codes, want;
    clear_log();
    codes = '{SOF, 5'd7, 5'd4, 5'd11, 5'd22, EOF};
    want  = '{5'd7, 5'd4, 5'd11};
    if (!CK) want.push_back(5'd22);
    send(codes, 1'b1);
    idle(8, 1'b1);
    checks++; if (dut_dones != 1) begin failures++; $display("FAIL basic_done got=%0d want=1", dut_dones); end
    checks++; if (!q_eq(popped, want)) begin failures++; $display("FAIL basic_letters got=%p want=%p", popped, want); end
    checks++; if (popped.size() > 0 && popcyc[popcyc.size()-1] - popcyc[0] + 1 != popped.size()) begin
      failures++; $display("FAIL basic_b2b span=%0d want=%0d", popcyc[popcyc.size()-1] - popcyc[0] + 1, popped.size()); end
    checks++; if (count_out !== '0 || data_valid_out !== 1'b0) begin
      failures++; $display("FAIL basic_empty got count=%0d valid=%0b want 0/0", count_out, data_valid_out); end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    send('{SOF, 5'd7, 5'd4, 5'd11, 5'd21, EOF}, 1'b1);
    idle(8, 1'b1);
    checks++; if (dut_drops != (CK ? 1 : 0)) begin failures++; $display("FAIL badck_drop got=%0d want=%0d", dut_drops, CK ? 1 : 0); end
    checks++; if (drop_count_out !== (CK ? 8'd1 : 8'd0)) begin failures++; $display("FAIL badck_dropcnt got=%0d want=%0d", drop_count_out, CK ? 1 : 0); end
    checks++; if (popped.size() != (CK ? 0 : 4)) begin failures++; $display("FAIL badck_out got=%0d letters want=%0d", popped.size(), CK ? 0 : 4); end
  endtask

  task automatic test_backpressure();
    q_t want;
    clear_log();
    send(mk_frame('{5'd7, 5'd4, 5'd11}), 1'b0);
    send(mk_frame('{5'd1, 5'd2, 5'd3}), 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0);
      checks++; if (count_out !== 5'd6 || data_out !== 5'd7 || data_valid_out !== 1'b1) begin
        failures++; $display("FAIL bp_hold i=%0d got count=%0d data=%0d valid=%0b want 6/7/1", i, count_out, data_out, data_valid_out); end
    end
    idle(10, 1'b1);
    want = '{5'd7, 5'd4, 5'd11, 5'd1, 5'd2, 5'd3};
    checks++; if (!q_eq(popped, want)) begin failures++; $display("FAIL bp_drain got=%p want=%p", popped, want); end
    checks++; if (count_out !== '0) begin failures++; $display("FAIL bp_count got=%0d want=0", count_out); end
  endtask

  task automatic test_overflow();
    q_t lt; int s, base;
    clear_log();
    do begin
      lt.delete(); s = 0;
      for (int i = 0; i < 14; i++) begin lt.push_back(DW'($urandom_range(0, 29))); s += int'(lt[i]); end
    end while (CK && (s % 32) >= 30);
    send(mk_frame(lt), 1'b0);
    idle(2, 1'b0);
    checks++; if (count_out !== 5'd14) begin failures++; $display("FAIL ovf_fill got=%0d want=14", count_out); end
    base = cyc;
    send('{SOF, 5'd1, 5'd2, 5'd3, EOF}, 1'b0);
    checks++; if (dut_drops != 1 || last_drop_cyc != base + 4) begin
      failures++; $display("FAIL ovf_drop got drops=%0d at=%0d want 1 at=%0d", dut_drops, last_drop_cyc, base + 4); end
    checks++; if (count_out !== 5'd14 || state_out !== 1'b0) begin
      failures++; $display("FAIL ovf_keep got count=%0d st=%0b want 14/0", count_out, state_out); end
    idle(18, 1'b1);
    checks++; if (!q_eq(popped, lt)) begin failures++; $display("FAIL ovf_intact got=%p want=%p", popped, lt); end
  endtask

  task automatic test_abort();
    clear_log();
    send('{SOF, 5'd5, 5'd6}, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    checks++; if (frame_drop_out !== 1'b1 || state_out !== 1'b0) begin
      failures++; $display("FAIL abort_err got drop=%0b st=%0b want 1/0", frame_drop_out, state_out); end
    send('{SOF, 5'd8, 5'd9, SOF}, 1'b1);
    checks++; if (frame_drop_out !== 1'b1 || state_out !== 1'b1) begin
      failures++; $display("FAIL abort_sof got drop=%0b st=%0b want 1/1", frame_drop_out, state_out); end
    send('{5'd10, 5'd12}, 1'b1);
    if (CK) send('{5'd22}, 1'b1);
    send('{EOF}, 1'b1);
    idle(5, 1'b1);
    checks++; if (!q_eq(popped, '{5'd10, 5'd12}) || dut_dones != 1 || dut_drops != 2) begin
      failures++; $display("FAIL abort_restart got=%p done=%0d drops=%0d want {10,12} 1 2", popped, dut_dones, dut_drops); end
  endtask

  task automatic test_simul();
    clear_log();
    send('{SOF, 5'd3}, 1'b1);
    step(1'b1, 5'd4, 1'b1, 1'b1);
    checks++; if (frame_drop_out !== 1'b1 || state_out !== 1'b0) begin
      failures++; $display("FAIL simul_drop got drop=%0b st=%0b want 1/0", frame_drop_out, state_out); end
    send('{5'd5, EOF}, 1'b1);
    idle(4, 1'b1);
    checks++; if (popped.size() != 0 || dut_dones != 0) begin
      failures++; $display("FAIL simul_discard got letters=%0d done=%0d want 0/0", popped.size(), dut_dones); end
  endtask

  task automatic test_reset_midframe();
    clear_log();
    send(mk_frame('{5'd9, 5'd9}), 1'b0);
    send('{SOF, 5'd1, 5'd2}, 1'b0);
    rst_in = 1; code_valid_in = 1; code_in = 5'd3;
    @(posedge clk_in); @(negedge clk_in);
    code_valid_in = 0;
    checks++; if ({data_valid_out, frame_done_out, frame_drop_out, state_out} !== 4'b0 || count_out !== '0 || drop_count_out !== '0) begin
      failures++; $display("FAIL rstmid_zero got v/d/dr/st=%b count=%0d dc=%0d want all 0",
        {data_valid_out, frame_done_out, frame_drop_out, state_out}, count_out, drop_count_out); end
    m_reset(); clear_log();
    rst_in = 0;
    send(mk_frame('{5'd5, 5'd6}), 1'b1);
    idle(5, 1'b1);
    checks++; if (!q_eq(popped, '{5'd5, 5'd6}) || dut_drops != 0) begin
      failures++; $display("FAIL rstmid_after got=%p drops=%0d want {5,6} 0", popped, dut_drops); end
  endtask

  task automatic test_random();
    stim_t sq[$]; int n, s; bit r;
    apply_reset(); rst_in = 0;
    for (int f = 0; f < 120; f++) begin
      if ($urandom_range(0, 9) == 0) sq.push_back('{1'b1, DW'($urandom_range(0, 29)), 1'b0});
      sq.push_back('{1'b1, SOF, 1'b0});
      n = $urandom_range(0, 18); s = 0;
      for (int i = 0; i < n; i++) begin
        sq.push_back('{1'b1, DW'($urandom_range(0, 29)), 1'b0});
        s += int'(sq[sq.size()-1].c);
        if ($urandom_range(0, 40) == 0) sq.push_back('{1'b0, 5'd0, 1'b1});
        if ($urandom_range(0, 40) == 0) sq.push_back('{1'b1, SOF, 1'b0});
        if ($urandom_range(0, 6) == 0) sq.push_back('{1'b0, 5'd0, 1'b0});
      end
      if (CK && $urandom_range(0, 4) != 0) sq.push_back('{1'b1, DW'(s), 1'b0});
      sq.push_back('{1'b1, EOF, $urandom_range(0, 30) == 0});
      for (int g = $urandom_range(0, 3); g > 0; g--) sq.push_back('{1'b0, 5'd0, 1'b0});
    end
    foreach (sq[i]) begin
      r = ($urandom_range(0, 9) < 7);
      step(sq[i].v, sq[i].c, sq[i].e, r);
      checks++;
      if (data_valid_out !== m_valid || data_out !== m_data || count_out !== PW'(m_count) ||
          frame_done_out !== m_done || frame_drop_out !== m_drop ||
          drop_count_out !== 8'(m_dropcnt) || state_out !== m_recv) begin
        failures++;
        $display("FAIL rnd_cycle i=%0d got v=%0b d=%0d n=%0d dn=%0b dr=%0b dc=%0d st=%0b want v=%0b d=%0d n=%0d dn=%0b dr=%0b dc=%0d st=%0b",
          i, data_valid_out, data_out, count_out, frame_done_out, frame_drop_out, drop_count_out, state_out,
          m_valid, m_data, m_count, m_done, m_drop, m_dropcnt, m_recv);
      end
    end
  endtask

  task automatic test_drop_sat();
    apply_reset(); rst_in = 0;
    for (int i = 0; i < 260; i++) begin
      step(1'b1, SOF, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b1);
      checks++; if (drop_count_out !== 8'(m_dropcnt)) begin
        failures++; $display("FAIL sat_step i=%0d got=%0d want=%0d", i, drop_count_out, m_dropcnt); end
    end
    checks++; if (drop_count_out !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d want=255", drop_count_out); end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_basic();
    test_bad_checksum();
    test_backpressure();
    test_overflow();
    test_abort();
    test_simul();
    test_reset_midframe();
    test_random();
    test_drop_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
